// File: rtl/vdp_pkg.sv
// Shared sprite-pipeline constants and the linebuffer write record.
// Pixel geometry here is fixed by the 64-bit linebuffer word (8 x 8-bit pixels).
package vdp_pkg;

   localparam int LB_ADDR_W    = 12;
   localparam int LB_WORD_W    = 9;
   localparam int PIX_PER_WORD = 8;

   localparam logic [3:0] TRANSPARENT_IDX = 4'h0;

   typedef struct packed {
      logic [LB_WORD_W-1:0]      addr;
      logic [8*PIX_PER_WORD-1:0] data;
      logic [PIX_PER_WORD-1:0]   be;
   } lb_write_t;

endpackage

// File: rtl/sprite_lb_writer_if.sv
// Span-command, pattern-fetch and linebuffer-write signals of the sprite linebuffer writer.
// The writer connects through 'slave'; the driving environment uses 'master'.
interface sprite_lb_writer_if;
   import vdp_pkg::*;

   logic                    in_valid;
   logic [8:0]              in_index;
   logic [LB_ADDR_W-1:0]    in_lb_x;
   logic [10:0]             in_sprite_x;
   logic [15:0]             in_pat_base;
   logic [3:0]              in_palette;
   logic                    pat_rd;
   logic [15:0]             pat_addr;
   logic [31:0]             pat_data;
   logic                    lb_we;
   logic [LB_WORD_W-1:0]    lb_waddr;
   logic [63:0]             lb_wdata;
   logic [PIX_PER_WORD-1:0] lb_wbe;

   modport slave (
      input  in_valid, in_index, in_lb_x, in_sprite_x, in_pat_base, in_palette, pat_data,
      output pat_rd, pat_addr, lb_we, lb_waddr, lb_wdata, lb_wbe
   );

   modport master (
      output in_valid, in_index, in_lb_x, in_sprite_x, in_pat_base, in_palette, pat_data,
      input  pat_rd, pat_addr, lb_we, lb_waddr, lb_wdata, lb_wbe
   );

endinterface

// File: rtl/sprite_span_align.sv
// Expands a 4bpp pattern word into 8 palette-tagged pixels and places them at slot
// shift..shift+7 of a 16-slot window split into low (word w) and high (word w+1) halves.
module sprite_span_align
   import vdp_pkg::*;
(
   input  logic [31:0]             pat_i,
   input  logic [2:0]              shift_i,
   input  logic [3:0]              palette_i,
   output logic [63:0]             lo_data_o,
   output logic [PIX_PER_WORD-1:0] lo_be_o,
   output logic [63:0]             hi_data_o,
   output logic [PIX_PER_WORD-1:0] hi_be_o
);

   logic [63:0]                span_data;
   logic [PIX_PER_WORD-1:0]    span_be;
   logic [127:0]               win_data;
   logic [2*PIX_PER_WORD-1:0]  win_be;

   // NOTE: every output of this block is assigned on every path before any
   // conditional use, which is what keeps always_comb free of inferred latches.
   always_comb begin
      span_data = '0;
      span_be   = '0;
      for (int i = 0; i < PIX_PER_WORD; i++) begin
         span_data[8*i +: 8] = {palette_i, pat_i[4*i +: 4]};
         span_be[i]          = (pat_i[4*i +: 4] != TRANSPARENT_IDX);
      end
      win_data = {64'b0, span_data} << {shift_i, 3'b000};
      win_be   = {8'b0, span_be} << shift_i;
   end

   assign lo_data_o = win_data[63:0];
   assign hi_data_o = win_data[127:64];
   assign lo_be_o   = win_be[7:0];
   assign hi_be_o   = win_be[15:8];

endmodule

// File: rtl/sprite_lb_writer.sv
// Sprite linebuffer writer: fetch, align and merge 8-pixel spans into byte-enabled writes.
// Optional macro SPRITE_LB_CLIP_EN suppresses writes at word addresses >= LB_WORDS.
module sprite_lb_writer
   import vdp_pkg::*;
#(
   parameter int LB_WORDS = 100
)
(
   input  logic               clk,
   input  logic               rst,
   input  logic               line,
   sprite_lb_writer_if.slave  lb_bus
);

   logic                    s1_valid_q;
   logic [LB_WORD_W-1:0]    s1_w_q;
   logic [2:0]              s1_s_q;
   logic [3:0]              s1_pal_q;

   logic                    carry_valid_q, carry_valid_d;
   lb_write_t               carry_q, carry_d;
   lb_write_t               wr_q, wr_d;
   logic                    we_q, we_d;
   logic                    carry_hit;

   logic [63:0]             lo_data, hi_data;
   logic [PIX_PER_WORD-1:0] lo_be, hi_be;

   assign lb_bus.pat_rd   = lb_bus.in_valid;
   assign lb_bus.pat_addr = lb_bus.in_valid ? lb_bus.in_pat_base + 16'(lb_bus.in_sprite_x) : '0;

   sprite_span_align u_align (
      .pat_i     (lb_bus.pat_data),
      .shift_i   (s1_s_q),
      .palette_i (s1_pal_q),
      .lo_data_o (lo_data),
      .lo_be_o   (lo_be),
      .hi_data_o (hi_data),
      .hi_be_o   (hi_be)
   );

   always_comb begin
      wr_d          = '0;
      carry_d       = carry_q;
      carry_valid_d = carry_valid_q;
      carry_hit     = carry_valid_q && (carry_q.addr == s1_w_q);
      if (s1_valid_q) begin
         wr_d.addr = s1_w_q;
         // Opaque pixels of the new span win; the overhang fills only its holes.
         for (int j = 0; j < PIX_PER_WORD; j++) begin
            if (!lo_be[j] && carry_hit && carry_q.be[j]) begin
               wr_d.data[8*j +: 8] = carry_q.data[8*j +: 8];
               wr_d.be[j]          = 1'b1;
            end else begin
               wr_d.data[8*j +: 8] = lo_data[8*j +: 8];
               wr_d.be[j]          = lo_be[j];
            end
         end
         carry_d.addr  = s1_w_q + 9'd1;
         carry_d.data  = hi_data;
         carry_d.be    = hi_be;
         carry_valid_d = 1'b1;
      end else if (carry_valid_q) begin
         wr_d          = carry_q;
         carry_valid_d = 1'b0;
      end
`ifdef SPRITE_LB_CLIP_EN
      we_d = (|wr_d.be) && (32'(wr_d.addr) < LB_WORDS);
`else
      we_d = |wr_d.be;
`endif
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst || line) begin
         s1_valid_q    <= 1'b0;
         carry_valid_q <= 1'b0;
         we_q          <= 1'b0;
         wr_q          <= '0;
      end else begin
         s1_valid_q    <= lb_bus.in_valid;
         carry_valid_q <= carry_valid_d;
         we_q          <= we_d;
         wr_q          <= wr_d;
      end
   end

   // NOTE: payload registers carry no reset; their valid bits above gate every use.
   always_ff @(posedge clk) begin
      s1_w_q   <= lb_bus.in_lb_x[LB_ADDR_W-1:3];
      s1_s_q   <= lb_bus.in_lb_x[2:0];
      s1_pal_q <= lb_bus.in_palette;
      carry_q  <= carry_d;
   end

   assign lb_bus.lb_we    = we_q;
   assign lb_bus.lb_waddr = wr_q.addr;
   assign lb_bus.lb_wdata = wr_q.data;
   assign lb_bus.lb_wbe   = wr_q.be;

endmodule
